// File: rtl/test_end_monitor.sv
// End-of-test monitor: watches DUT beat/done/error, enforces cycle budget,
// inter-beat watchdog and minimum beat count, then issues one registered verdict.
module test_end_monitor #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_max_cycles,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic [CNT_W-1:0] cfg_min_beats,
  input  logic             beat,
  input  logic             done,
  input  logic             error,
  output logic             running,
  output logic             finish_req,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] beat_count
);

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ERROR    = 3'd1;
  localparam logic [2:0] FC_WATCHDOG = 3'd2;
  localparam logic [2:0] FC_BUDGET   = 3'd3;
  localparam logic [2:0] FC_UNDERRUN = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_max_cycles;
  logic [CNT_W-1:0]  r_min_beats;
  logic [TO_W-1:0]   r_timeout;
  logic [TO_W-1:0]   r_idle_cnt;

  logic [CNT_W:0]    w_cyc_inc;
  logic [CNT_W:0]    w_beat_tot;
  logic [TO_W:0]     w_idle_inc;
  logic [CNT_W-1:0]  w_cyc_nxt;
  logic [CNT_W-1:0]  w_beat_nxt;
  logic [TO_W-1:0]   w_idle_nxt;
  logic              w_min_met;
  logic              w_wd_fire;
  logic              w_budget_fire;
  logic              w_end;
  logic              w_pass;
  logic [2:0]        w_code;

  // Counter arithmetic is one bit wider so compares and saturation never wrap.
  always_comb begin
    w_cyc_inc     = {1'b0, cycle_count} + {{CNT_W{1'b0}}, 1'b1};
    w_beat_tot    = {1'b0, beat_count} + {{CNT_W{1'b0}}, beat};
    w_idle_inc    = {1'b0, r_idle_cnt} + {{TO_W{1'b0}}, 1'b1};
    w_cyc_nxt     = w_cyc_inc[CNT_W]  ? cycle_count : w_cyc_inc[CNT_W-1:0];
    w_beat_nxt    = w_beat_tot[CNT_W] ? beat_count  : w_beat_tot[CNT_W-1:0];
    w_idle_nxt    = beat ? '0 : (w_idle_inc[TO_W] ? r_idle_cnt : w_idle_inc[TO_W-1:0]);
    w_min_met     = w_beat_tot >= {1'b0, r_min_beats};
    w_wd_fire     = (r_timeout != '0) && !beat && (w_idle_inc >= {1'b0, r_timeout});
    w_budget_fire = w_cyc_inc > {1'b0, r_max_cycles};
  end

  // Verdict for the current RUN cycle, highest priority first.
  always_comb begin
    w_end  = 1'b1;
    w_pass = 1'b0;
    w_code = FC_NONE;
    if (error) begin
      w_code = FC_ERROR;
    end else if (done) begin
      if (w_min_met) w_pass = 1'b1;
      else           w_code = FC_UNDERRUN;
    end else if (w_wd_fire) begin
      w_code = FC_WATCHDOG;
    end else if (w_budget_fire) begin
      w_code = FC_BUDGET;
    end else begin
      w_end = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_max_cycles <= '0;
      r_min_beats  <= '0;
      r_timeout    <= '0;
      r_idle_cnt   <= '0;
      running      <= 1'b0;
      finish_req   <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      fail_code    <= FC_NONE;
      cycle_count  <= '0;
      beat_count   <= '0;
    end else begin
      finish_req <= 1'b0;
      case (r_state)
        S_RUN: begin
          cycle_count <= w_cyc_nxt;
          beat_count  <= w_beat_nxt;
          r_idle_cnt  <= w_idle_nxt;
          if (w_end) begin
            r_state    <= w_pass ? S_PASS : S_FAIL;
            running    <= 1'b0;
            finish_req <= 1'b1;
            pass       <= w_pass;
            fail       <= !w_pass;
            fail_code  <= w_code;
          end
        end
        default: begin
          // IDLE, PASS and FAIL all restart identically on start.
          if (start) begin
            r_state      <= S_RUN;
            r_max_cycles <= cfg_max_cycles;
            r_min_beats  <= cfg_min_beats;
            r_timeout    <= cfg_timeout;
            r_idle_cnt   <= '0;
            running      <= 1'b1;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= FC_NONE;
            cycle_count  <= '0;
            beat_count   <= '0;
          end
        end
      endcase
    end
  end

endmodule
